// File: rtl/fpadd_sequencer.sv
// Round-robin sequencer for the shared FP adder: arbitrates two requesters, steps the
// datapath through LOAD/ALIGN/ADD/NORM/ROUND and returns a held, tagged response.
module fpadd_sequencer #(
    parameter int unsigned NORM_TIMEOUT = 32,
    parameter logic [31:0] QNAN         = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_a0,
    input  logic [31:0] req_b0,
    input  logic [31:0] req_a1,
    input  logic [31:0] req_b1,
    output logic [31:0] dp_a,
    output logic [31:0] dp_b,
    output logic        dp_load,
    output logic        dp_align_en,
    output logic        dp_add_en,
    output logic        dp_norm_en,
    output logic        dp_round_en,
    input  logic        dp_norm_done,
    input  logic [31:0] dp_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = $clog2(NORM_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(NORM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          id_q, id_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] data_q, data_d;
    logic          err_q, err_d;
    logic          load_q, align_q, add_q, norm_q, round_q, valid_q;
    logic          grant;

    // Special-operand classification on the loaded operands
    logic          exp_a_max, exp_b_max, nan_a, nan_b, inf_a, inf_b, special;
    logic [DW-1:0] bypass_data;

    assign exp_a_max = (a_q[30:23] == 8'hFF);
    assign exp_b_max = (b_q[30:23] == 8'hFF);
    assign nan_a     = exp_a_max && (a_q[22:0] != 23'd0);
    assign nan_b     = exp_b_max && (b_q[22:0] != 23'd0);
    assign inf_a     = exp_a_max && (a_q[22:0] == 23'd0);
    assign inf_b     = exp_b_max && (b_q[22:0] == 23'd0);
    assign special   = exp_a_max || exp_b_max;

    always_comb begin
        if (nan_a || nan_b) begin
            bypass_data = QNAN;
        end else if (inf_a && inf_b && (a_q[31] != b_q[31])) begin
            bypass_data = QNAN;
        end else if (inf_a) begin
            bypass_data = a_q;
        end else begin
            bypass_data = b_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        a_d          = a_q;
        b_d          = b_q;
        cnt_d        = cnt_q;
        data_d       = data_q;
        err_d        = err_q;
        grant        = 1'b0;
        req_ready    = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (!reset && (req_valid != 2'b00)) begin
                    grant            = (&req_valid) ? ~last_grant_q : ~req_valid[0];
                    req_ready[grant] = 1'b1;
                    last_grant_d     = grant;
                    id_d             = grant;
                    a_d              = grant ? req_a1 : req_a0;
                    b_d              = grant ? req_b1 : req_b0;
                    state_d          = S_LOAD;
                end
            end
            S_LOAD: begin
                if (special) begin
                    data_d  = bypass_data;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else begin
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: state_d = S_ADD;
            S_ADD: begin
                cnt_d   = '0;
                state_d = S_NORM;
            end
            S_NORM: begin
                // done takes priority over the final allowed cycle
                cnt_d = cnt_q + CW'(1);
                if (dp_norm_done) begin
                    state_d = S_ROUND;
                end else if (cnt_q == CNT_LAST) begin
                    data_d  = QNAN;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_ROUND: begin
                data_d  = dp_result;
                err_d   = 1'b0;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            cnt_q        <= '0;
            data_q       <= '0;
            err_q        <= 1'b0;
            load_q       <= 1'b0;
            align_q      <= 1'b0;
            add_q        <= 1'b0;
            norm_q       <= 1'b0;
            round_q      <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            err_q        <= err_d;
            load_q       <= (state_d == S_LOAD);
            align_q      <= (state_d == S_ALIGN);
            add_q        <= (state_d == S_ADD);
            norm_q       <= (state_d == S_NORM);
            round_q      <= (state_d == S_ROUND);
            valid_q      <= (state_d == S_RESP);
        end
    end

    assign dp_a        = a_q;
    assign dp_b        = b_q;
    assign dp_load     = load_q;
    assign dp_align_en = align_q;
    assign dp_add_en   = add_q;
    assign dp_norm_en  = norm_q;
    assign dp_round_en = round_q;
    assign rsp_valid   = valid_q;
    assign rsp_id      = id_q;
    assign rsp_data    = data_q;
    assign rsp_err     = err_q;

endmodule

// File: tb/tb_fpadd_sequencer.sv
// Directed bench for fpadd_sequencer: latency, arbitration, bypass, timeout,
// backpressure and mid-operation reset, with hand-computed expectations.
module tb_fpadd_sequencer;

    localparam logic [31:0] QNAN_C = 32'h7FC00000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [31:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic [31:0] dp_a, dp_b;
    logic        dp_load, dp_align_en, dp_add_en, dp_norm_en, dp_round_en;
    logic        dp_norm_done = 1'b0;
    logic [31:0] dp_result = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [4:0]  strobes;

    int checks = 0;
    int errors = 0;

    assign strobes = {dp_load, dp_align_en, dp_add_en, dp_norm_en, dp_round_en};

    fpadd_sequencer #(.NORM_TIMEOUT(32), .QNAN(32'h7FC00000)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .dp_a(dp_a), .dp_b(dp_b),
        .dp_load(dp_load), .dp_align_en(dp_align_en), .dp_add_en(dp_add_en),
        .dp_norm_en(dp_norm_en), .dp_round_en(dp_round_en),
        .dp_norm_done(dp_norm_done), .dp_result(dp_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 2'b00;
        tick();
        tick();
        checks++;
        if (req_ready !== 2'b00) begin
            errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready);
        end
        checks++;
        if (strobes !== 5'b00000) begin
            errors++; $display("FAIL reset_strobes: got %b expected 00000", strobes);
        end
        checks++;
        if ({dp_a, dp_b} !== 64'd0) begin
            errors++; $display("FAIL reset_dp_ops: got %h %h expected 0 0", dp_a, dp_b);
        end
        checks++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== 35'd0) begin
            errors++; $display("FAIL reset_rsp: got v=%b id=%b d=%h e=%b expected all 0",
                               rsp_valid, rsp_id, rsp_data, rsp_err);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        logic [4:0] exp_s [5];
        exp_s = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};
        dp_norm_done = 1'b1;
        dp_result = 32'h40400000;
        rsp_ready = 1'b1;
        req_a0 = 32'h3F800000;
        req_b0 = 32'h40000000;
        req_valid = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL single_ready: got %b expected 01", req_ready);
        end
        tick();
        req_valid = 2'b00;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (strobes !== exp_s[i]) begin
                errors++; $display("FAIL single_strobe T+%0d: got %b expected %b", i + 1, strobes, exp_s[i]);
            end
            if (i == 0) begin
                checks++;
                if ({dp_a, dp_b} !== {32'h3F800000, 32'h40000000}) begin
                    errors++; $display("FAIL single_dp_ops: got %h %h expected 3f800000 40000000", dp_a, dp_b);
                end
            end
            tick();
        end
        checks++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, 1'b0, 32'h40400000, 1'b0}) begin
            errors++; $display("FAIL single_rsp T+6: got v=%b id=%b d=%h e=%b expected 1 0 40400000 0",
                               rsp_valid, rsp_id, rsp_data, rsp_err);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL single_rsp_drop: got %b expected 0", rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        int ng = 0;
        int nr = 0;
        int dpa_bad = 0;
        logic both_seen = 1'b0;
        logic [3:0] gseq = '0;
        logic [3:0] rseq = '0;
        reset = 1'b1;
        req_valid = 2'b00;
        tick();
        reset = 1'b0;
        req_a0 = 32'h3F800000; req_b0 = 32'h40000000;
        req_a1 = 32'h40800000; req_b1 = 32'h40000000;
        dp_norm_done = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        for (int cyc = 0; cyc < 100 && nr < 4; cyc++) begin
            #1;
            if (req_ready == 2'b11) both_seen = 1'b1;
            if (dp_load && ng > 0) begin
                if (dp_a !== (gseq[ng-1] ? 32'h40800000 : 32'h3F800000)) dpa_bad++;
            end
            if (req_ready != 2'b00 && ng < 4) begin
                gseq[ng] = req_ready[1];
                ng++;
            end
            if (rsp_valid) begin
                rseq[nr] = rsp_id;
                nr++;
            end
            if (nr == 4) req_valid = 2'b00;
            tick();
        end
        checks++;
        if (nr !== 4) begin
            errors++; $display("FAIL rr_count: got %0d responses expected 4", nr);
        end
        checks++;
        if (gseq !== 4'b1010) begin
            errors++; $display("FAIL rr_grants: got %b expected 1010 (lsb first 0,1,0,1)", gseq);
        end
        checks++;
        if (rseq !== 4'b1010) begin
            errors++; $display("FAIL rr_rsp_ids: got %b expected 1010 (lsb first 0,1,0,1)", rseq);
        end
        checks++;
        if (both_seen !== 1'b0) begin
            errors++; $display("FAIL rr_ready_onehot: got both-high=%b expected 0", both_seen);
        end
        checks++;
        if (dpa_bad !== 0) begin
            errors++; $display("FAIL rr_dp_a_source: got %0d wrong loads expected 0", dpa_bad);
        end
    endtask

    task automatic test_bypass(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_d);
        req_a0 = a;
        req_b0 = b;
        rsp_ready = 1'b1;
        req_valid = 2'b01;
        #1;
        tick();
        req_valid = 2'b00;
        checks++;
        if (strobes !== 5'b10000) begin
            errors++; $display("FAIL bypass_load %h+%h: got %b expected 10000", a, b, strobes);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_data, rsp_err, strobes} !== {1'b1, exp_d, 1'b0, 5'b00000}) begin
            errors++; $display("FAIL bypass_rsp %h+%h: got v=%b d=%h e=%b s=%b expected 1 %h 0 00000",
                               a, b, rsp_valid, rsp_data, rsp_err, strobes, exp_d);
        end
        tick();
    endtask

    task automatic test_norm_late(input int n, input logic [31:0] res);
        int nn = 0;
        int lat = 0;
        dp_norm_done = 1'b0;
        dp_result = res;
        rsp_ready = 1'b1;
        req_a0 = 32'h3F800000;
        req_b0 = 32'h3F800000;
        req_valid = 2'b01;
        #1;
        tick();
        req_valid = 2'b00;
        for (int cyc = 1; cyc < 120; cyc++) begin
            if (dp_norm_en) begin
                nn++;
                if (nn == n) dp_norm_done = 1'b1;
            end
            if (rsp_valid) begin
                lat = cyc;
                break;
            end
            tick();
        end
        checks++;
        if (nn !== n || lat !== 5 + n) begin
            errors++; $display("FAIL norm_late n=%0d: got norm=%0d lat=%0d expected norm=%0d lat=%0d",
                               n, nn, lat, n, 5 + n);
        end
        checks++;
        if ({rsp_valid, rsp_data, rsp_err} !== {1'b1, res, 1'b0}) begin
            errors++; $display("FAIL norm_late_rsp n=%0d: got v=%b d=%h e=%b expected 1 %h 0",
                               n, rsp_valid, rsp_data, rsp_err, res);
        end
        tick();
        dp_norm_done = 1'b0;
    endtask

    task automatic test_timeout();
        int nn = 0;
        logic got = 1'b0;
        dp_norm_done = 1'b0;
        dp_result = 32'h12345678;
        rsp_ready = 1'b1;
        req_a0 = 32'h3F800000;
        req_b0 = 32'h40000000;
        req_valid = 2'b01;
        #1;
        tick();
        req_valid = 2'b00;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            if (dp_norm_en) nn++;
            tick();
        end
        checks++;
        if (got !== 1'b1 || nn !== 32) begin
            errors++; $display("FAIL timeout_norm_cycles: got rsp=%b norm=%0d expected 1 32", got, nn);
        end
        checks++;
        if ({rsp_data, rsp_err} !== {QNAN_C, 1'b1}) begin
            errors++; $display("FAIL timeout_rsp: got d=%h e=%b expected %h 1", rsp_data, rsp_err, QNAN_C);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL timeout_rsp_drop: got %b expected 0", rsp_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [36:0] exp_v;
        exp_v = {1'b1, 1'b1, 32'h7F800000, 1'b0, 2'b00};
        rsp_ready = 1'b0;
        req_a1 = 32'h7F800000;
        req_b1 = 32'h3F800000;
        req_valid = 2'b10;
        #1;
        tick();
        req_a0 = 32'h3F800000;
        req_b0 = 32'h3F800000;
        req_valid = 2'b11;
        tick();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({rsp_valid, rsp_id, rsp_data, rsp_err, req_ready} !== exp_v) begin
                errors++; $display("FAIL backpressure_hold %0d: got v=%b id=%b d=%h e=%b rdy=%b expected 1 1 7f800000 0 00",
                                   i, rsp_valid, rsp_id, rsp_data, rsp_err, req_ready);
            end
            tick();
        end
        rsp_ready = 1'b1;
        req_valid = 2'b00;
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++; $display("FAIL backpressure_release: got %b expected 1", rsp_valid);
        end
        tick();
        req_valid = 2'b01;
        #1;
        checks++;
        if ({rsp_valid, req_ready} !== 3'b001) begin
            errors++; $display("FAIL backpressure_idle: got v=%b rdy=%b expected 0 01", rsp_valid, req_ready);
        end
        req_valid = 2'b00;
        #1;
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        logic got = 1'b0;
        dp_norm_done = 1'b0;
        rsp_ready = 1'b1;
        req_a0 = 32'h3F800000;
        req_b0 = 32'h40000000;
        req_valid = 2'b01;
        #1;
        tick();
        req_valid = 2'b00;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (dp_norm_en) break;
            tick();
        end
        checks++;
        if (dp_norm_en !== 1'b1) begin
            errors++; $display("FAIL midreset_reach_norm: got %b expected 1", dp_norm_en);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({strobes, rsp_valid, rsp_err, dp_a} !== 39'd0) begin
            errors++; $display("FAIL midreset_state: got s=%b v=%b e=%b a=%h expected all 0",
                               strobes, rsp_valid, rsp_err, dp_a);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rsp_valid || strobes != 5'b00000) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL midreset_quiet: got %0d active cycles expected 0", bad);
        end
        req_a1 = 32'h40400000;
        req_b1 = 32'h3F800000;
        dp_norm_done = 1'b1;
        dp_result = 32'h40800000;
        req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++; $display("FAIL midreset_ready1: got %b expected 10", req_ready);
        end
        tick();
        req_valid = 2'b00;
        checks++;
        if ({strobes, dp_a} !== {5'b10000, 32'h40400000}) begin
            errors++; $display("FAIL midreset_load1: got s=%b a=%h expected 10000 40400000", strobes, dp_a);
        end
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if ({got, rsp_id, rsp_data, rsp_err} !== {1'b1, 1'b1, 32'h40800000, 1'b0}) begin
            errors++; $display("FAIL midreset_rsp1: got v=%b id=%b d=%h e=%b expected 1 1 40800000 0",
                               got, rsp_id, rsp_data, rsp_err);
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_bypass(32'h7F800000, 32'hFF800000, 32'h7FC00000);
        test_bypass(32'h7F800000, 32'h3F800000, 32'h7F800000);
        test_bypass(32'h3F800000, 32'hFF800000, 32'hFF800000);
        test_bypass(32'h7F800000, 32'h7F800000, 32'h7F800000);
        test_bypass(32'h3F800000, 32'h7F800001, 32'h7FC00000);
        test_norm_late(3, 32'h40A00000);
        test_norm_late(32, 32'h41200000);
        test_timeout();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
